// File: rtl/evo_rst_seq.sv
// Power/reset sequencer: releases reset domains in ascending order on en1mhz ticks once PLL
// lock is stable, drains them in reverse on a 4-phase software request, drops all on lock loss.
module evo_rst_seq #(
    parameter int NUM_DOMAINS = 4,
    parameter int DELAY_US    = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk_bsp,
    input  logic                   reset_n,
    input  logic                   en1mhz,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    input  logic                   clr_lock_lost,
    output logic [NUM_DOMAINS-1:0] dom_rstn,
    output logic                   sw_rst_ack,
    output logic [1:0]             seq_state,
    output logic                   seq_busy,
    output logic                   lock_lost
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int DLY_I = (DELAY_US < 1) ? 1 : DELAY_US;
    localparam logic [CNT_WIDTH-1:0] DLY      = CNT_WIDTH'(DLY_I);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } seq_state_e;

    logic                   lock_meta_r;
    logic                   lock_sync_r;
    seq_state_e             state_r,  state_s;
    logic [IDX_W-1:0]       idx_r,    idx_s;
    logic [CNT_WIDTH-1:0]   cnt_r,    cnt_s;
    logic [NUM_DOMAINS-1:0] dom_r,    dom_s;
    logic                   ack_r,    ack_s;
    logic                   pend_r,   pend_s;
    logic                   lost_r,   lost_s;
    logic                   busy_r,   busy_s;
    logic                   pend_set_s;
    logic                   lock_drop_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk_bsp or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_bsp or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_HOLD;
            idx_r   <= '0;
            cnt_r   <= '0;
            dom_r   <= '0;
            ack_r   <= 1'b0;
            pend_r  <= 1'b0;
            lost_r  <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            dom_r   <= dom_s;
            ack_r   <= ack_s;
            pend_r  <= pend_s;
            lost_r  <= lost_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic; lock loss outranks every other event.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        dom_s       = dom_r;
        ack_s       = ack_r & sw_rst_req;
        pend_set_s  = sw_rst_req & ~ack_r;
        pend_s      = pend_r;
        lost_s      = clr_lock_lost ? 1'b0 : lost_r;
        lock_drop_s = (state_r != ST_HOLD) && !lock_sync_r;

        if (lock_drop_s) begin
            state_s = ST_HOLD;
            idx_s   = '0;
            dom_s   = '0;
            lost_s  = 1'b1;
            pend_s  = pend_r | pend_set_s;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    dom_s  = '0;
                    idx_s  = '0;
                    pend_s = pend_r | pend_set_s;
                    if (lock_sync_r) begin
                        state_s = ST_RELEASE;
                        cnt_s   = DLY;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    pend_s = pend_r | pend_set_s;
                    if (en1mhz) begin
                        if (cnt_r == CNT_ONE) begin
                            dom_s[idx_r] = 1'b1;
                            if (idx_r == IDX_LAST) begin
                                // A pending request is acknowledged on arrival in RUN.
                                state_s = ST_RUN;
                                ack_s   = ack_s | pend_s;
                                pend_s  = 1'b0;
                            end else begin
                                idx_s = idx_r + IDX_ONE;
                                cnt_s = DLY;
                            end
                        end else begin
                            cnt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_RUN: begin
                    dom_s = '1;
                    if (pend_set_s) begin
                        pend_s  = 1'b1;
                        state_s = ST_DRAIN;
                        idx_s   = IDX_LAST;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (en1mhz) begin
                        dom_s[idx_r] = 1'b0;
                        if (idx_r == '0) begin
                            state_s = ST_RELEASE;
                            idx_s   = '0;
                            cnt_s   = DLY;
                        end else begin
                            idx_s = idx_r - IDX_ONE;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                default: begin
                    state_s = ST_HOLD;
                    idx_s   = '0;
                    dom_s   = '0;
                end
            endcase
        end

        busy_s = (state_s != ST_RUN);
    end

    assign dom_rstn   = dom_r;
    assign sw_rst_ack = ack_r;
    assign seq_state  = state_r;
    assign seq_busy   = busy_r;
    assign lock_lost  = lost_r;

endmodule

// File: tb/tb_evo_rst_seq.sv
// Self-checking bench for evo_rst_seq: randomized en1mhz spacing against a pulse-count model.
module tb_evo_rst_seq;

    localparam int N   = 4;
    localparam int DLY = 8;

    logic         clk_bsp = 1'b0;
    logic         reset_n, en1mhz, pll_locked, sw_rst_req, clr_lock_lost;
    logic [N-1:0] dom_rstn;
    logic         sw_rst_ack, seq_busy, lock_lost;
    logic [1:0]   seq_state;

    logic         reset_n_f, en_f, pll_f, req_f, clr_f;
    logic [N-1:0] dom_f;
    logic         ack_f, busy_f, lost_f;
    logic [1:0]   state_f;

    int checks = 0;
    int errors = 0;

    always #5 clk_bsp = ~clk_bsp;

    evo_rst_seq u_dut (
        .clk_bsp       (clk_bsp),
        .reset_n       (reset_n),
        .en1mhz        (en1mhz),
        .pll_locked    (pll_locked),
        .sw_rst_req    (sw_rst_req),
        .clr_lock_lost (clr_lock_lost),
        .dom_rstn      (dom_rstn),
        .sw_rst_ack    (sw_rst_ack),
        .seq_state     (seq_state),
        .seq_busy      (seq_busy),
        .lock_lost     (lock_lost)
    );

    evo_rst_seq #(.NUM_DOMAINS(4), .DELAY_US(0), .CNT_WIDTH(8)) u_fast (
        .clk_bsp       (clk_bsp),
        .reset_n       (reset_n_f),
        .en1mhz        (en_f),
        .pll_locked    (pll_f),
        .sw_rst_req    (req_f),
        .clr_lock_lost (clr_f),
        .dom_rstn      (dom_f),
        .sw_rst_ack    (ack_f),
        .seq_state     (state_f),
        .seq_busy      (busy_f),
        .lock_lost     (lost_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: n low domains out of reset.
    function automatic logic [N-1:0] ones(input int n);
        int m;
        int v;
        m = (n < 0) ? 0 : ((n > N) ? N : n);
        v = (1 << m) - 1;
        return v[N-1:0];
    endfunction

    function automatic logic [N-1:0] exp_rel(input int pulses);
        return ones(pulses / DLY);
    endfunction

    task automatic step();
        @(posedge clk_bsp);
        #1;
    endtask

    task automatic tick();
        en1mhz = 1'b1;
        step();
        en1mhz = 1'b0;
    endtask

    task automatic idle();
        int n;
        n = int'($urandom_range(0, 3));
        repeat (n) step();
    endtask

    task automatic run_release(input string tag, input int npulses);
        for (int p = 1; p <= npulses; p++) begin
            tick();
            chk(tag, 32'(dom_rstn), 32'(exp_rel(p)));
            chk(tag, 32'(seq_state), (p >= N * DLY) ? 32'd2 : 32'd1);
            if (p < npulses) idle();
        end
    endtask

    task automatic run_drain(input string tag);
        for (int k = 1; k <= N; k++) begin
            tick();
            chk(tag, 32'(dom_rstn), 32'(ones(N - k)));
            chk(tag, 32'(seq_state), (k == N) ? 32'd1 : 32'd3);
            idle();
        end
    endtask

    initial begin
        reset_n = 1'b0; en1mhz = 1'b0; pll_locked = 1'b0; sw_rst_req = 1'b0; clr_lock_lost = 1'b0;
        reset_n_f = 1'b0; en_f = 1'b1; pll_f = 1'b0; req_f = 1'b0; clr_f = 1'b0;
        repeat (3) step();
        chk("rst_dom", 32'(dom_rstn), 32'd0);
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd1);
        chk("rst_ack", 32'(sw_rst_ack), 32'd0);
        chk("rst_lost", 32'(lock_lost), 32'd0);

        // 1: power-up release
        reset_n = 1'b1;
        pll_locked = 1'b1;
        repeat (5) step();
        chk("t1_entry_state", 32'(seq_state), 32'd1);
        chk("t1_entry_dom", 32'(dom_rstn), 32'd0);
        run_release("t1_rel", N * DLY);
        chk("t1_busy", 32'(seq_busy), 32'd0);
        chk("t1_lost", 32'(lock_lost), 32'd0);
        idle();

        // 2: software reset, request held through re-release
        sw_rst_req = 1'b1;
        step();
        chk("t2_drain_state", 32'(seq_state), 32'd3);
        chk("t2_drain_dom", 32'(dom_rstn), 32'hF);
        chk("t2_drain_busy", 32'(seq_busy), 32'd1);
        run_drain("t2_drain");
        run_release("t2_rel", N * DLY);
        chk("t2_ack_rise", 32'(sw_rst_ack), 32'd1);
        repeat (6) step();
        chk("t2_no_redrain", 32'(seq_state), 32'd2);
        chk("t2_ack_held", 32'(sw_rst_ack), 32'd1);
        sw_rst_req = 1'b0;
        step();
        chk("t2_ack_fall", 32'(sw_rst_ack), 32'd0);

        // 3: lock loss mid-release with a request in flight
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("t3_drain_state", 32'(seq_state), 32'd3);
        run_drain("t3_drain");
        run_release("t3_rel", 2 * DLY);
        idle();
        pll_locked = 1'b0;
        step();
        step();
        chk("t3_pre_dom", 32'(dom_rstn), 32'h3);
        chk("t3_pre_state", 32'(seq_state), 32'd1);
        step();
        chk("t3_loss_dom", 32'(dom_rstn), 32'd0);
        chk("t3_loss_state", 32'(seq_state), 32'd0);
        chk("t3_loss_lost", 32'(lock_lost), 32'd1);
        chk("t3_loss_busy", 32'(seq_busy), 32'd1);
        clr_lock_lost = 1'b1;
        step();
        clr_lock_lost = 1'b0;
        chk("t3_clr", 32'(lock_lost), 32'd0);
        pll_locked = 1'b1;
        repeat (5) step();
        chk("t3_relock_state", 32'(seq_state), 32'd1);
        run_release("t3_relock", N * DLY);
        chk("t3_pend_ack", 32'(sw_rst_ack), 32'd1);
        step();
        chk("t3_ack_fall", 32'(sw_rst_ack), 32'd0);

        // 4: lock loss coincident with clear
        chk("t4_pre_lost", 32'(lock_lost), 32'd0);
        pll_locked = 1'b0;
        step();
        step();
        clr_lock_lost = 1'b1;
        step();
        clr_lock_lost = 1'b0;
        chk("t4_set_wins", 32'(lock_lost), 32'd1);
        chk("t4_state", 32'(seq_state), 32'd0);
        chk("t4_dom", 32'(dom_rstn), 32'd0);

        // 5: request raised in HOLD, held through release and beyond
        sw_rst_req = 1'b1;
        step();
        step();
        chk("t5_hold_ack", 32'(sw_rst_ack), 32'd0);
        chk("t5_hold_state", 32'(seq_state), 32'd0);
        pll_locked = 1'b1;
        repeat (5) step();
        run_release("t5_rel", N * DLY);
        chk("t5_ack", 32'(sw_rst_ack), 32'd1);
        for (int r = 0; r < 3; r++) begin
            idle();
            tick();
            chk("t5_no_drain", 32'(seq_state), 32'd2);
            chk("t5_dom", 32'(dom_rstn), 32'hF);
            chk("t5_ack_held", 32'(sw_rst_ack), 32'd1);
        end
        chk("t5_lost_sticky", 32'(lock_lost), 32'd1);
        sw_rst_req = 1'b0;
        step();
        chk("t5_ack_fall", 32'(sw_rst_ack), 32'd0);

        // 6: zero delay with en1mhz tied high, then async reset mid-drain
        reset_n_f = 1'b1;
        step();
        pll_f = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t6_rel_dom", 32'(dom_f), 32'(ones(k - 3)));
            chk("t6_rel_state", 32'(state_f), (k <= 2) ? 32'd0 : ((k == 7) ? 32'd2 : 32'd1));
        end
        req_f = 1'b1;
        step();
        chk("t6_drain_state", 32'(state_f), 32'd3);
        step();
        chk("t6_drain_dom1", 32'(dom_f), 32'h7);
        step();
        chk("t6_drain_dom2", 32'(dom_f), 32'h3);
        reset_n_f = 1'b0;
        #1;
        chk("t6_arst_dom", 32'(dom_f), 32'd0);
        chk("t6_arst_state", 32'(state_f), 32'd0);
        chk("t6_arst_busy", 32'(busy_f), 32'd1);
        chk("t6_arst_ack", 32'(ack_f), 32'd0);
        chk("t6_arst_lost", 32'(lost_f), 32'd0);
        step();
        step();
        chk("t6_arst_hold", 32'(dom_f), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
